diag_cram_seq: RTL and testbench

Diagnostic-side sequencer that loads and reads back one CRAM word over the diagnostic function bus and EBUS. It is the initiator counterpart of the CRAM slice boards. Those boards decode DIAG LOAD FUNC 05x and DIAG READ FUNC 14x and drive or accept EBUS bits. This block issues those function codes, strobes, and data in the required order, then assembles the read-back word. It sits between the console/diagnostic controller and the EBUS diagnostic lines.

---
 rtl/diag_cram_seq.sv | 153 +++++++++++++++
 tb/tb_diag_cram_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diag_cram_seq.sv
// Diagnostic-side initiator that loads or reads back one CRAM word by stepping
// DIAG function codes, load/read strobes and EBUS data through SETUP/STROBE/HOLD.
module diag_cram_seq #(
  parameter int STROBE_CYCLES = 2
) (
  input  logic         clk_diag_h,
  input  logic         mr_reset_l,
  input  logic         start_h,
  input  logic         write_h,
  input  logic         abort_h,
  input  logic [0:10]  adr,
  input  logic [0:83]  wdata,
  output logic         busy_h,
  output logic         done_h,
  output logic [0:83]  rdata,
  output logic [6:0]   diag_func,
  output logic         diag_load_h,
  output logic         diag_read_h,
  output logic [0:35]  ebus_out,
  output logic         ebus_out_en_h,
  input  logic [0:35]  ebus_in
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] STB_LAST = 3'(STROBE_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  cnt;
  logic [2:0]  step;
  logic        wr_p0;
  logic [0:10] adr_p0;
  logic [0:83] wdata_p0;
  logic [6:0]  func_cur;
  logic        active;
  logic        last_step;
  logic        is_load;
  logic        is_read;

  function automatic logic [6:0] step_func(input logic wr, input logic [2:0] idx);
    logic [6:0] f;
    f = 7'o000;
    if (wr) begin
      case (idx)
        3'd0:    f = 7'o051;
        3'd1:    f = 7'o052;
        3'd2:    f = 7'o053;
        3'd3:    f = 7'o054;
        3'd4:    f = 7'o050;
        default: f = 7'o000;
      endcase
    end else begin
      case (idx)
        3'd0:    f = 7'o051;
        3'd1:    f = 7'o140;
        3'd2:    f = 7'o141;
        3'd3:    f = 7'o142;
        default: f = 7'o000;
      endcase
    end
    return f;
  endfunction

  assign func_cur  = step_func(wr_p0, step);
  assign active    = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign last_step = wr_p0 ? (step == 3'd4) : (step == 3'd3);
  assign is_load   = (func_cur[6:3] == 4'b0101);
  assign is_read   = (func_cur[6:3] == 4'b1100);

  // Control state and read-back word; abort overrides any step progress, including a pending sample.
  always_ff @(posedge clk_diag_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      step  <= 3'd0;
      wr_p0 <= 1'b0;
      rdata <= '0;
    end else if (abort_h && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_h) begin
            state <= S_SETUP;
            step  <= 3'd0;
            wr_p0 <= write_h;
          end
        end
        S_SETUP: begin
          state <= S_STROBE;
          cnt   <= 3'd0;
        end
        S_STROBE: begin
          if (cnt == STB_LAST) begin
            state <= S_HOLD;
            case (func_cur)
              7'o140:  rdata[0:35]  <= ebus_in;
              7'o141:  rdata[36:71] <= ebus_in;
              7'o142:  rdata[72:83] <= ebus_in[24:35];
              default: ;
            endcase
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_HOLD: begin
          if (last_step) begin
            state <= S_DONE;
          end else begin
            state <= S_SETUP;
            step  <= step + 3'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture at start; data path only, so no reset.
  always_ff @(posedge clk_diag_h) begin
    if ((state == S_IDLE) && start_h) begin
      adr_p0   <= adr;
      wdata_p0 <= wdata;
    end
  end

  assign busy_h        = active;
  assign done_h        = (state == S_DONE);
  assign diag_func     = active ? func_cur : 7'o000;
  assign ebus_out_en_h = active && is_load;
  assign diag_load_h   = (state == S_STROBE) && is_load;
  assign diag_read_h   = (state == S_STROBE) && is_read;

  // Outputs decode straight from the async-reset state, so reset drops strobes without a clock.
  always_comb begin
    ebus_out = '0;
    if (ebus_out_en_h) begin
      case (func_cur)
        7'o051:  ebus_out[25:35] = adr_p0;
        7'o052:  ebus_out        = wdata_p0[0:35];
        7'o053:  ebus_out        = wdata_p0[36:71];
        7'o054:  ebus_out[24:35] = wdata_p0[72:83];
        default: ebus_out        = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_diag_cram_seq.sv
// Bench for diag_cram_seq: three instances (STROBE_CYCLES 2, 1, 7) checked every cycle
// against a cycle-position model, plus literal expectations from the worked examples.
module tb_diag_cram_seq;

  localparam logic [0:35] R140 = 36'o123456701234;
  localparam logic [0:35] R141 = 36'o765432107654;
  localparam logic [0:35] R142 = 36'o777777774321;

  logic        clk = 1'b0;
  logic        mr_reset_l = 1'b1;
  logic        start_h = 1'b0;
  logic        write_h = 1'b0;
  logic        abort_h = 1'b0;
  logic [0:10] adr = '0;
  logic [0:83] wdata = '0;

  logic        busy_a[3], done_a[3], ld_a[3], rs_a[3], en_a[3];
  logic [6:0]  func_a[3];
  logic [0:35] eo_a[3], ei_a[3];
  logic [0:83] rdata_a[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [0:35] resp(input logic [6:0] f);
    case (f)
      7'o140:  return R140;
      7'o141:  return R141;
      7'o142:  return R142;
      default: return 36'h0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SC = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    assign ei_a[g] = resp(func_a[g]);
    diag_cram_seq #(.STROBE_CYCLES(SC)) u_dut (
      .clk_diag_h(clk), .mr_reset_l(mr_reset_l), .start_h(start_h), .write_h(write_h),
      .abort_h(abort_h), .adr(adr), .wdata(wdata), .busy_h(busy_a[g]), .done_h(done_a[g]),
      .rdata(rdata_a[g]), .diag_func(func_a[g]), .diag_load_h(ld_a[g]), .diag_read_h(rs_a[g]),
      .ebus_out(eo_a[g]), .ebus_out_en_h(en_a[g]), .ebus_in(ei_a[g])
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int step_len(input int i);
    return (i == 0) ? 4 : (i == 1) ? 3 : 9;
  endfunction

  // Expected outputs from position t within an operation (t=0 idle, t=1 first SETUP cycle).
  function automatic void model_out(input int L, input int t, input bit wr,
                                    input logic [0:10] a, input logic [0:83] d,
                                    output logic [6:0] f, output bit ld, output bit rs,
                                    output bit en, output bit bsy, output bit dn,
                                    output logic [0:35] eb);
    int n, s, ph;
    bit strobe, lf, rf;
    n = wr ? 5 : 4;
    f = 7'o0; ld = 0; rs = 0; en = 0; bsy = 0; dn = 0; eb = '0;
    if (t >= 1 && t <= n * L) begin
      s = (t - 1) / L;
      ph = (t - 1) % L;
      bsy = 1;
      if (wr) begin
        case (s)
          0: f = 7'o051; 1: f = 7'o052; 2: f = 7'o053; 3: f = 7'o054; default: f = 7'o050;
        endcase
      end else begin
        case (s)
          0: f = 7'o051; 1: f = 7'o140; 2: f = 7'o141; default: f = 7'o142;
        endcase
      end
      strobe = (ph >= 1) && (ph <= L - 2);
      lf = (f >= 7'o050) && (f <= 7'o057);
      rf = (f >= 7'o140) && (f <= 7'o147);
      en = lf;
      ld = strobe && lf;
      rs = strobe && rf;
      case (f)
        7'o051: eb[25:35] = a;
        7'o052: eb = d[0:35];
        7'o053: eb = d[36:71];
        7'o054: eb[24:35] = d[72:83];
        default: eb = '0;
      endcase
    end else if (t == n * L + 1) begin
      dn = 1;
    end
  endfunction

  int          mt[3] = '{0, 0, 0};
  bit          mwr[3];
  logic [0:10] mad[3];
  logic [0:83] mwd[3];
  logic [0:83] mrd[3] = '{84'h0, 84'h0, 84'h0};

  initial begin
    logic [6:0]  ef;
    bit          eld, ers, een, ebs, edn;
    logic [0:35] eeb;
    logic [0:35] r2;
    int          L, n, s, ph;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        L = step_len(i);
        if (!mr_reset_l) begin
          mt[i] = 0;
          mrd[i] = '0;
        end
        model_out(L, mt[i], mwr[i], mad[i], mwd[i], ef, eld, ers, een, ebs, edn, eeb);
        chk($sformatf("busy[%0d] t=%0d", i, mt[i]), busy_a[i], ebs);
        chk($sformatf("done[%0d] t=%0d", i, mt[i]), done_a[i], edn);
        chk($sformatf("func[%0d] t=%0d", i, mt[i]), func_a[i], ef);
        chk($sformatf("load[%0d] t=%0d", i, mt[i]), ld_a[i], eld);
        chk($sformatf("read[%0d] t=%0d", i, mt[i]), rs_a[i], ers);
        chk($sformatf("en[%0d] t=%0d", i, mt[i]), en_a[i], een);
        chk($sformatf("ebus[%0d] t=%0d", i, mt[i]), eo_a[i], eeb);
        chk($sformatf("rdata[%0d] t=%0d", i, mt[i]), rdata_a[i], mrd[i]);
        if (mr_reset_l) begin
          n = mwr[i] ? 5 : 4;
          if (mt[i] == 0) begin
            if (start_h) begin
              mt[i] = 1; mwr[i] = write_h; mad[i] = adr; mwd[i] = wdata;
            end
          end else if (abort_h) begin
            mt[i] = 0;
          end else begin
            if (mt[i] <= n * L && !mwr[i]) begin
              s = (mt[i] - 1) / L;
              ph = (mt[i] - 1) % L;
              r2 = R142;
              if (ph == L - 2) begin
                case (s)
                  1: mrd[i][0:35] = R140;
                  2: mrd[i][36:71] = R141;
                  3: mrd[i][72:83] = r2[24:35];
                  default: ;
                endcase
              end
            end
            if (mt[i] == n * L + 1) mt[i] = 0;
            else mt[i] = mt[i] + 1;
          end
        end
      end
    end
  end

  bit          rb[3][64], rdn[3][64], rld[3][64], rrs[3][64], ren[3][64];
  logic [6:0]  rf[3][64];
  logic [0:35] reb[3][64];
  logic [0:83] rrd[64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start in the current cycle (cycle 0), then records cycles 1..ncyc.
  task automatic run_op(input bit wr, input logic [0:10] a, input logic [0:83] d,
                        input int ncyc, input bit hold_start);
    start_h = 1; write_h = wr; adr = a; wdata = d;
    tick();
    if (!hold_start) start_h = 0;
    for (int k = 1; k <= ncyc; k++) begin
      for (int i = 0; i < 3; i++) begin
        rb[i][k] = busy_a[i]; rdn[i][k] = done_a[i]; rld[i][k] = ld_a[i];
        rrs[i][k] = rs_a[i]; ren[i][k] = en_a[i]; rf[i][k] = func_a[i]; reb[i][k] = eo_a[i];
      end
      rrd[k] = rdata_a[0];
      tick();
    end
    start_h = 0;
  endtask

  initial begin
    int  n, dk;
    bit  sawdone;
    #1 mr_reset_l = 1'b0;
    repeat (3) tick();
    chk("reset busy", busy_a[0], 1'b0);
    chk("reset rdata", rdata_a[0], 84'h0);
    chk("reset func", func_a[0], 7'o0);
    mr_reset_l = 1'b1;
    tick();

    // Write on all three instances (strobe widths 2, 1, 7).
    run_op(1'b1, 11'o1234, 84'h123456789ABCDEF012345, 48, 1'b0);
    chk("wr func 051", rf[0][1], 7'o051);
    chk("wr func 052", rf[0][5], 7'o052);
    chk("wr func 053", rf[0][9], 7'o053);
    chk("wr func 054", rf[0][13], 7'o054);
    chk("wr func 050", rf[0][17], 7'o050);
    chk("wr ebus 051", reb[0][1], 36'o1234);
    chk("wr ebus 052", reb[0][5], 36'h123456789);
    chk("wr ebus 053", reb[0][9], 36'hABCDEF012);
    chk("wr ebus 054", reb[0][13], 36'h000000345);
    n = 0;
    for (int k = 1; k <= 4; k++) n += int'(rld[0][k]);
    chk("wr strobe width 2", n, 2);
    chk("wr strobe c2", rld[0][2], 1'b1);
    chk("wr busy c20", rb[0][20], 1'b1);
    chk("wr done c21", rdn[0][21], 1'b1);
    chk("wr busy c21", rb[0][21], 1'b0);
    chk("wr rdata untouched", rrd[21], 84'h0);
    n = 0;
    for (int k = 1; k <= 3; k++) n += int'(rld[1][k]);
    chk("sc1 strobe width", n, 1);
    chk("sc1 done c16", rdn[1][16], 1'b1);
    n = 0;
    for (int k = 1; k <= 9; k++) n += int'(rld[2][k]);
    chk("sc7 strobe width", n, 7);
    chk("sc7 done c46", rdn[2][46], 1'b1);
    chk("sc7 busy c45", rb[2][45], 1'b1);

    // Read with the responder model.
    run_op(1'b0, 11'o0017, 84'h0, 40, 1'b0);
    chk("rd ebus 051", reb[0][1], 36'o17);
    chk("rd done c17", rdn[0][17], 1'b1);
    chk("rd busy c16", rb[0][16], 1'b1);
    chk("rd rdata c17", rrd[17], {36'o123456701234, 36'o765432107654, 12'o4321});
    n = 0;
    for (int k = 1; k <= 16; k++) n += int'(ren[0][k]);
    chk("rd en cycles", n, 4);
    chk("rd en c4", ren[0][4], 1'b1);
    chk("rd read strobe c6", rrs[0][6], 1'b1);
    chk("rd read strobe c8", rrs[0][8], 1'b0);
    chk("rd no load strobe 140", rld[0][6], 1'b0);

    // Abort in cycle 9 of a write, new read start in cycle 10.
    start_h = 1; write_h = 1; adr = 11'o0555; wdata = 84'hFEDCBA9876543210FEDCB;
    tick();
    start_h = 0;
    sawdone = 0;
    for (int k = 1; k <= 8; k++) begin
      sawdone |= done_a[0];
      tick();
    end
    abort_h = 1;
    sawdone |= done_a[0];
    tick();
    abort_h = 0;
    chk("abort busy c10", busy_a[0], 1'b0);
    chk("abort load c10", ld_a[0], 1'b0);
    chk("abort en c10", en_a[0], 1'b0);
    chk("abort func c10", func_a[0], 7'o0);
    chk("abort done c10", done_a[0] | sawdone, 1'b0);
    start_h = 1; write_h = 0; adr = 11'o0017;
    tick();
    start_h = 0;
    chk("abort restart busy c11", busy_a[0], 1'b1);
    dk = 0;
    for (int k = 11; k <= 30; k++) begin
      if (done_a[0] && dk == 0) dk = k;
      tick();
    end
    chk("abort restart done c27", dk, 27);
    repeat (40) tick();

    // start_h held through a read.
    run_op(1'b0, 11'o0017, 84'h0, 20, 1'b1);
    chk("held done c17", rdn[0][17], 1'b1);
    chk("held busy c17", rb[0][17], 1'b0);
    chk("held idle c18", rb[0][18], 1'b0);
    chk("held second op c19", rb[0][19], 1'b1);
    chk("held busy c10", rb[0][10], 1'b1);
    repeat (40) tick();

    // Async reset during STROBE of step 053.
    start_h = 1; write_h = 1; adr = 11'o1234; wdata = 84'h123456789ABCDEF012345;
    tick();
    start_h = 0;
    repeat (9) tick();
    #2;
    chk("pre-reset load c10", ld_a[0], 1'b1);
    mr_reset_l = 1'b0;
    #1;
    chk("async reset load", ld_a[0], 1'b0);
    chk("async reset busy", busy_a[0], 1'b0);
    chk("async reset en", en_a[0], 1'b0);
    chk("async reset func", func_a[0], 7'o0);
    chk("async reset ebus", eo_a[0], 36'h0);
    chk("async reset rdata", rdata_a[0], 84'h0);
    tick();
    mr_reset_l = 1'b1;
    repeat (4) tick();
    chk("post reset rdata", rdata_a[0], 84'h0);
    chk("post reset busy", busy_a[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
